press_count_bank: RTL and testbench
===================================

// Module: press_count_bank
// PURPOSE
//  Parametrised multi-channel successor to the single 8-bit press counter.
//  Each channel takes raw up/down button levels, synchronises and debounces
//  them, and counts one event per debounced rising edge (not per held cycle).
//  Counters wrap or saturate, can be cleared per channel, and flag changes.
//  Sits between the board button pins and the display/readout logic.
// PARAMETERS
//  NRCH      2   number of independent counter channels (>=1)
//  WIDTH     8   counter width per channel, bits (2..32)
//  DEBOUNCE  4   consecutive stable cycles before a debounced level changes (>=1)
//  SATURATE  0   0: wrap modulo 2^WIDTH; 1: clamp at 0 and 2^WIDTH-1
// PORTS
//  clock       in   1            system clock, all logic on rising edge
//  reset       in   1            synchronous, active-high
//  countu      in   NRCH         raw up-button level per channel (async to clock)
//  countd      in   NRCH         raw down-button level per channel (async to clock)
//  clear       in   NRCH         synchronous per-channel counter clear, level
//  nr_presses  out  NRCH*WIDTH   counts; channel i at [i*WIDTH +: WIDTH]
//  changed     out  NRCH         1-cycle pulse: channel count changed this edge
//  at_limit    out  NRCH         SATURATE=1: a step was blocked by a clamp (pulse)
// BEHAVIOUR
//  - Single clock; reset synchronous and active-high, dominates all inputs.
//  - Reset: nr_presses=0, changed=0, at_limit=0; sync flops, debounced levels,
//    edge-history flops and debounce counters all 0.
//  - Per input (countu[i], countd[i]): 2-flop synchroniser -> s.
//    Debouncer holds level deb, counter cnt (clog2(DEBOUNCE+1) bits):
//    s==deb -> cnt<=0; s!=deb && cnt==DEBOUNCE-1 -> deb<=s, cnt<=0;
//    else cnt<=cnt+1. Glitches shorter than DEBOUNCE cycles are discarded.
//  - Edge: press = deb & ~deb_q (deb_q = deb delayed 1 cycle). Falling edges
//    and held levels never count.
//  - Latency: raw input first sampled high at edge 0 -> count updates at edge
//    DEBOUNCE+2 (DEBOUNCE+3 edges inclusive); changed pulses the same cycle.
//  - Per-channel update priority, evaluated each edge:
//    1. clear[i]=1: count<=0; changed=1 iff old count!=0; pending presses lost.
//    2. up_press && down_press same cycle: no change, changed=0.
//    3. up_press: count+1; down_press: count-1.
//  - Wrap (SATURATE=0): 2^WIDTH-1 +1 -> 0; 0 -1 -> 2^WIDTH-1; changed=1.
//  - Saturate (SATURATE=1): max +1 and 0 -1 hold value; changed=0, at_limit=1.
//  - Channels fully independent; no cross-channel interaction.
//  - Button held through reset: deb restarts at 0, so it counts exactly once
//    DEBOUNCE+2 edges after reset deasserts (counting treats it as new press).
//  - Reset mid-debounce or mid-press: all state lost, no partial count kept.
//  - Outputs are registered; no combinational input->output path.
// STRUCTURE
//  - Shared include press_count_defs.vh: `PC_MODE_WRAP=0, `PC_MODE_SAT=1,
//    clog2 helper function, default WIDTH/DEBOUNCE values.
//  - Sub-module press_count_channel (sync+debounce x2, edge detect, counter,
//    flags); top instantiates NRCH copies in a generate loop and packs buses.
//  - Debouncer kept inside the channel module.
// TESTING  (NRCH=2, WIDTH=8, DEBOUNCE=4, clock period 4 ns unless noted)
//  - Reset: hold reset 2 cycles with countu=2'b11 -> all outputs 0 during
//    reset; each channel reaches 1 exactly 6 edges after reset low, then holds.
//  - Debounce: countu[0] high 3 cycles -> no change; high 200 cycles -> ch0=1,
//    one changed[0] pulse; ch1 unchanged.
//  - Up/down/simultaneous: 5 up presses then 2 down on ch1 -> ch1=3; countu[1]
//    and countd[1] rising together -> ch1 stays 3, changed[1]=0.
//  - Wrap (SATURATE=0): from 0, one down press -> 255, changed=1; next up -> 0.
//  - Saturate (SATURATE=1, WIDTH=2): 5 up presses -> 3, at_limit pulses twice;
//    4 down presses -> 0, at_limit pulses once.
//  - Clear priority: clear[0]=1 coincident with ch0 press at count 7 -> 0,
//    changed[0]=1; clear at count 0 -> changed[0]=0.

Source files
------------

// File: rtl/press_count_bank_pkg.sv
// Shared definitions for the press counter bank:
// counting modes, default sizes and a clog2 helper.
package press_count_bank_pkg;

    localparam int PC_MODE_WRAP    = 0;
    localparam int PC_MODE_SAT     = 1;
    localparam int PC_WIDTH_DEF    = 8;
    localparam int PC_DEBOUNCE_DEF = 4;

    // Ceiling log2, never less than 1 so counters stay at least 1 bit.
    function automatic int pc_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/press_count_channel.sv
// One counter channel: synchronise and debounce the up/down
// buttons, detect debounced rising edges, count with wrap/clamp.
module press_count_channel
    import press_count_bank_pkg::*;
#(
    parameter int WIDTH    = PC_WIDTH_DEF,
    parameter int DEBOUNCE = PC_DEBOUNCE_DEF,
    parameter int SATURATE = PC_MODE_WRAP
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             up_i,
    input  logic             down_i,
    input  logic             clear_i,
    output logic [WIDTH-1:0] count_o,
    output logic             changed_o,
    output logic             at_limit_o
);

    localparam int CW = pc_clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] DLAST = CW'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] CMAX = '1;
    localparam logic [WIDTH-1:0] CZERO = '0;
    localparam bit SAT = (SATURATE == PC_MODE_SAT);

    // Index 0 is the up button, index 1 the down button.
    logic [1:0]         raw;
    logic [1:0]         meta_q;
    logic [1:0]         sync_q;
    logic [1:0]         deb_q;
    logic [1:0]         deb_d;
    logic [1:0]         deb_dly_q;
    logic [1:0][CW-1:0] dcnt_q;
    logic [1:0][CW-1:0] dcnt_d;

    logic             up_press;
    logic             down_press;
    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;
    logic             chg_q;
    logic             chg_d;
    logic             lim_q;
    logic             lim_d;

    assign raw = {down_i, up_i};

    // Debounce: a level change is accepted after DEBOUNCE
    // consecutive cycles of disagreement; any agreement restarts.
    always_comb begin
        deb_d  = deb_q;
        dcnt_d = '0;
        for (int k = 0; k < 2; k++) begin
            if (sync_q[k] != deb_q[k]) begin
                if (dcnt_q[k] == DLAST) begin
                    deb_d[k] = sync_q[k];
                end else begin
                    dcnt_d[k] = dcnt_q[k] + CW'(1);
                end
            end
        end
    end

    // Synchroniser, debounce state and edge-history registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q    <= '0;
            sync_q    <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            dcnt_q    <= '0;
        end else begin
            meta_q    <= raw;
            sync_q    <= meta_q;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            dcnt_q    <= dcnt_d;
        end
    end

    assign up_press   = deb_q[0] & ~deb_dly_q[0];
    assign down_press = deb_q[1] & ~deb_dly_q[1];

    // Counter update: clear beats presses, opposing presses cancel.
    always_comb begin
        cnt_d = cnt_q;
        chg_d = 1'b0;
        lim_d = 1'b0;
        if (clear_i) begin
            cnt_d = '0;
            chg_d = (cnt_q != CZERO);
        end else if (up_press && down_press) begin
            cnt_d = cnt_q;
        end else if (up_press) begin
            if (SAT && cnt_q == CMAX) begin
                lim_d = 1'b1;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
                chg_d = 1'b1;
            end
        end else if (down_press) begin
            if (SAT && cnt_q == CZERO) begin
                lim_d = 1'b1;
            end else begin
                cnt_d = cnt_q - WIDTH'(1);
                chg_d = 1'b1;
            end
        end
    end

    // Registered count and flag outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            chg_q <= 1'b0;
            lim_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            chg_q <= chg_d;
            lim_q <= lim_d;
        end
    end

    assign count_o    = cnt_q;
    assign changed_o  = chg_q;
    assign at_limit_o = lim_q;

endmodule

// File: rtl/press_count_bank.sv
// Bank of independent press counters between the button
// pins and the readout logic; packs channel results onto buses.
module press_count_bank
    import press_count_bank_pkg::*;
#(
    parameter int NRCH     = 2,
    parameter int WIDTH    = PC_WIDTH_DEF,
    parameter int DEBOUNCE = PC_DEBOUNCE_DEF,
    parameter int SATURATE = PC_MODE_WRAP
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NRCH-1:0]       countu,
    input  logic [NRCH-1:0]       countd,
    input  logic [NRCH-1:0]       clear,
    output logic [NRCH*WIDTH-1:0] nr_presses,
    output logic [NRCH-1:0]       changed,
    output logic [NRCH-1:0]       at_limit
);

    for (genvar g = 0; g < NRCH; g++) begin : g_ch
        press_count_channel #(
            .WIDTH    (WIDTH),
            .DEBOUNCE (DEBOUNCE),
            .SATURATE (SATURATE)
        ) u_ch (
            .clk_i      (clock),
            .rst_i      (reset),
            .up_i       (countu[g]),
            .down_i     (countd[g]),
            .clear_i    (clear[g]),
            .count_o    (nr_presses[g*WIDTH +: WIDTH]),
            .changed_o  (changed[g]),
            .at_limit_o (at_limit[g])
        );
    end

endmodule

// File: tb/tb_press_count_bank.sv
// Self-checking bench: a wrapping 8-bit bank and a saturating
// 2-bit bank, compared against an event-level counting model.
module tb_press_count_bank;

    localparam int DEB = 4;

    logic        clk;
    logic        reset;
    logic [1:0]  countu, countd, clear;
    logic [15:0] nr;
    logic [1:0]  changed, at_limit;
    logic [1:0]  countu_s, countd_s, clear_s;
    logic [3:0]  nr_s;
    logic [1:0]  changed_s, at_limit_s;

    int checks = 0;
    int errors = 0;
    int m_cnt[2];
    int ms_cnt[2];
    int chg_tot[2];
    int chgs_tot[2];
    int lims_tot[2];

    press_count_bank #(.NRCH(2), .WIDTH(8), .DEBOUNCE(DEB), .SATURATE(0)) dut (
        .clock(clk), .reset(reset), .countu(countu), .countd(countd),
        .clear(clear), .nr_presses(nr), .changed(changed),
        .at_limit(at_limit)
    );

    press_count_bank #(.NRCH(2), .WIDTH(2), .DEBOUNCE(DEB), .SATURATE(1)) dut_s (
        .clock(clk), .reset(reset), .countu(countu_s), .countd(countd_s),
        .clear(clear_s), .nr_presses(nr_s), .changed(changed_s),
        .at_limit(at_limit_s)
    );

    initial clk = 1'b0;
    always #2 clk = ~clk;

    initial begin
        for (int i = 0; i < 2; i++) begin
            chg_tot[i] = 0;
            chgs_tot[i] = 0;
            lims_tot[i] = 0;
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chg_tot[i]  = chg_tot[i] + int'(changed[i]);
            chgs_tot[i] = chgs_tot[i] + int'(changed_s[i]);
            lims_tot[i] = lims_tot[i] + int'(at_limit_s[i]);
        end
    end

    function automatic int cnt_of(input bit sat, input int ch);
        if (sat) return int'(nr_s[ch*2 +: 2]);
        return int'(nr[ch*8 +: 8]);
    endfunction

    // One button event; kind 0=up, 1=down, 2=both together.
    task automatic press(input bit sat, input int ch, input int kind,
                         input int hi, input int lo);
        int c0, l0, old, nw, ec, el, oc;
        c0 = sat ? chgs_tot[ch] : chg_tot[ch];
        l0 = lims_tot[ch];
        if (sat) begin
            if (kind != 1) countu_s[ch] = 1'b1;
            if (kind != 0) countd_s[ch] = 1'b1;
        end else begin
            if (kind != 1) countu[ch] = 1'b1;
            if (kind != 0) countd[ch] = 1'b1;
        end
        repeat (hi) @(negedge clk);
        countu = '0; countd = '0; countu_s = '0; countd_s = '0;
        repeat (lo) @(negedge clk);
        old = sat ? ms_cnt[ch] : m_cnt[ch];
        nw = old; ec = 0; el = 0;
        if (hi >= DEB && kind != 2) begin
            if (!sat) begin
                nw = (kind == 0) ? (old + 1) % 256 : (old + 255) % 256;
                ec = 1;
            end else if (kind == 0 && old == 3) el = 1;
            else if (kind == 1 && old == 0) el = 1;
            else begin
                nw = (kind == 0) ? old + 1 : old - 1;
                ec = 1;
            end
        end
        if (sat) ms_cnt[ch] = nw; else m_cnt[ch] = nw;
        checks++;
        if (cnt_of(sat, ch) !== nw) begin
            errors++;
            $display("FAIL count s%0d ch%0d: got %0d exp %0d",
                     sat, ch, cnt_of(sat, ch), nw);
        end
        checks++;
        oc = sat ? chgs_tot[ch] - c0 : chg_tot[ch] - c0;
        if (oc !== ec) begin
            errors++;
            $display("FAIL changed s%0d ch%0d: got %0d exp %0d",
                     sat, ch, oc, ec);
        end
        checks++;
        if (cnt_of(sat, 1 - ch) !== (sat ? ms_cnt[1-ch] : m_cnt[1-ch])) begin
            errors++;
            $display("FAIL indep s%0d ch%0d: got %0d", sat, 1 - ch,
                     cnt_of(sat, 1 - ch));
        end
        if (sat) begin
            checks++;
            if (lims_tot[ch] - l0 !== el) begin
                errors++;
                $display("FAIL at_limit ch%0d: got %0d exp %0d", ch,
                         lims_tot[ch] - l0, el);
            end
        end
    endtask

    task automatic do_clear(input bit sat, input int ch);
        int c0, ec;
        c0 = sat ? chgs_tot[ch] : chg_tot[ch];
        ec = ((sat ? ms_cnt[ch] : m_cnt[ch]) != 0) ? 1 : 0;
        if (sat) clear_s[ch] = 1'b1; else clear[ch] = 1'b1;
        @(negedge clk);
        clear = '0; clear_s = '0;
        repeat (3) @(negedge clk);
        if (sat) ms_cnt[ch] = 0; else m_cnt[ch] = 0;
        checks++;
        if (cnt_of(sat, ch) !== 0 ||
            (sat ? chgs_tot[ch] : chg_tot[ch]) - c0 !== ec) begin
            errors++;
            $display("FAIL clear s%0d ch%0d: cnt %0d chg %0d exp chg %0d",
                     sat, ch, cnt_of(sat, ch),
                     (sat ? chgs_tot[ch] : chg_tot[ch]) - c0, ec);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        countu = 2'b11;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (nr !== 16'h0 || changed !== 2'b00 || at_limit !== 2'b00 ||
                nr_s !== 4'h0) begin
                errors++;
                $display("FAIL reset_vals: nr=%h chg=%b lim=%b nr_s=%h",
                         nr, changed, at_limit, nr_s);
            end
        end
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (nr !== 16'h0) begin
                errors++;
                $display("FAIL reset_early edge %0d: nr=%h exp 0000", i, nr);
            end
        end
        @(negedge clk);
        checks++;
        if (nr !== 16'h0101 || changed !== 2'b11) begin
            errors++;
            $display("FAIL reset_held: nr=%h chg=%b exp 0101/11", nr, changed);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (nr !== 16'h0101 || changed !== 2'b00) begin
            errors++;
            $display("FAIL reset_hold: nr=%h chg=%b exp 0101/00", nr, changed);
        end
        countu = 2'b00;
        repeat (12) @(negedge clk);
        m_cnt[0] = 1; m_cnt[1] = 1;
        ms_cnt[0] = 0; ms_cnt[1] = 0;
    endtask

    task automatic test_debounce();
        press(0, 0, 0, 3, 10);
        press(0, 0, 0, 200, 10);
    endtask

    task automatic test_updown();
        do_clear(0, 1);
        repeat (5) press(0, 1, 0, 8, 10);
        repeat (2) press(0, 1, 1, 8, 10);
        checks++;
        if (nr[15:8] !== 8'd3) begin
            errors++;
            $display("FAIL updown: got %0d exp 3", nr[15:8]);
        end
        press(0, 1, 2, 8, 10);
    endtask

    task automatic test_wrap();
        do_clear(0, 0);
        press(0, 0, 1, 8, 10);
        checks++;
        if (nr[7:0] !== 8'd255) begin
            errors++;
            $display("FAIL wrap_down: got %0d exp 255", nr[7:0]);
        end
        press(0, 0, 0, 8, 10);
        checks++;
        if (nr[7:0] !== 8'd0) begin
            errors++;
            $display("FAIL wrap_up: got %0d exp 0", nr[7:0]);
        end
    endtask

    task automatic test_clear_priority();
        do_clear(0, 0);
        repeat (7) press(0, 0, 0, 8, 10);
        countu[0] = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        checks++;
        if (nr[7:0] !== 8'd0 || changed[0] !== 1'b1) begin
            errors++;
            $display("FAIL clr_prio: cnt %0d chg %b exp 0/1",
                     nr[7:0], changed[0]);
        end
        m_cnt[0] = 0;
        repeat (3) @(negedge clk);
        checks++;
        if (nr[7:0] !== 8'd0) begin
            errors++;
            $display("FAIL clr_lost: cnt %0d exp 0", nr[7:0]);
        end
        countu = '0;
        repeat (12) @(negedge clk);
        clear[0] = 1'b1;
        @(negedge clk);
        clear[0] = 1'b0;
        checks++;
        if (changed[0] !== 1'b0 || nr[7:0] !== 8'd0) begin
            errors++;
            $display("FAIL clr_zero: chg %b cnt %0d exp 0/0",
                     changed[0], nr[7:0]);
        end
    endtask

    task automatic test_saturate();
        int l0;
        l0 = lims_tot[0];
        repeat (5) press(1, 0, 0, 8, 10);
        checks++;
        if (nr_s[1:0] !== 2'd3 || lims_tot[0] - l0 !== 2) begin
            errors++;
            $display("FAIL sat_up: cnt %0d lim %0d exp 3/2",
                     nr_s[1:0], lims_tot[0] - l0);
        end
        l0 = lims_tot[0];
        repeat (4) press(1, 0, 1, 8, 10);
        checks++;
        if (nr_s[1:0] !== 2'd0 || lims_tot[0] - l0 !== 1) begin
            errors++;
            $display("FAIL sat_down: cnt %0d lim %0d exp 0/1",
                     nr_s[1:0], lims_tot[0] - l0);
        end
    endtask

    task automatic test_random();
        int ch, op, hi;
        for (int n = 0; n < 60; n++) begin
            ch = int'($urandom_range(1, 0));
            op = int'($urandom_range(9, 0));
            hi = (op == 9) ? int'($urandom_range(3, 1))
                           : int'($urandom_range(10, 4));
            if (op == 8) do_clear(n % 2 == 1, ch);
            else press(n % 2 == 1, ch, op % 3, hi,
                       int'($urandom_range(12, 8)));
        end
    endtask

    initial begin
        countu = '0; countd = '0; clear = '0;
        countu_s = '0; countd_s = '0; clear_s = '0;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_debounce();
        test_updown();
        test_wrap();
        test_clear_priority();
        test_saturate();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
